start_token_fifo_srl: RTL



---
 rtl/start_token_fifo_srl_pkg.sv | 12 +
 rtl/start_token_srl_store.sv | 32 +++
 rtl/start_token_fifo_srl.sv | 70 +++++++
 3 files changed

// File: rtl/start_token_fifo_srl_pkg.sv
// Shared constants and types for the start-token FIFO that carries the HLS
// start/ready token between dataflow processes.
package start_token_fifo_srl_pkg;

  localparam int START_TOKEN_W      = 1;
  localparam int FIFO_DEPTH_DEFAULT = 13;
  localparam int FIFO_ADDR_W        = 4;

  // Occupancy holds 0..DEPTH, so it needs one bit more than the read address.
  typedef logic [FIFO_ADDR_W:0] occ_t;

endpackage

// File: rtl/start_token_srl_store.sv
// Shift-register token store: a push shifts every slot up by one and loads slot 0.
// The storage has no reset.
module start_token_srl_store #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 13
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] store [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      store[0] <= din;
      for (int i = 1; i < DEPTH; i++) store[i] <= store[i-1];
    end
  end

  // Decoded read mux; addresses at or beyond DEPTH only occur when the FIFO is empty.
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_WIDTH'(i)) dout = store[i];
    end
  end

endmodule

// File: rtl/start_token_fifo_srl.sv
// First-word-fall-through start-token FIFO: shift-register store plus
// registered full/empty flags derived from the next occupancy.
//   state   | meaning
//   EMPTY   | count == 0, if_empty_n = 0
//   PARTIAL | 1 <= count <= DEPTH-1, both flags high
//   FULL    | count == DEPTH, if_full_n = 0
module start_token_fifo_srl
  import start_token_fifo_srl_pkg::*;
#(
  parameter int DATA_WIDTH = START_TOKEN_W,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = FIFO_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout
);

  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

  logic                  push, pop;
  logic [ADDR_WIDTH:0]   count, count_next, count_m1;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign push = if_write & if_write_ce & if_full_n;
  assign pop  = if_read & if_read_ce & if_empty_n;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_ONE;
    else if (pop && !push) count_next = count - CNT_ONE;
  end

  // Newest token sits in slot 0, so the oldest lives at count-1.
  assign count_m1 = count - CNT_ONE;
  assign rd_addr  = count_m1[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      if_empty_n <= 1'b0;
      if_full_n  <= 1'b1;
    end else begin
      count      <= count_next;
      if_empty_n <= (count_next != '0);
      if_full_n  <= (count_next != CNT_FULL);
    end
  end

  start_token_srl_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_store (
    .clk  (clk),
    .we   (push),
    .addr (rd_addr),
    .din  (if_din),
    .dout (if_dout)
  );

endmodule
